booth_r4_mul_seq: RTL
=====================

Name: booth_r4_mul_seq

Overview:
- Parametrised sequential radix-4 Booth multiplier. Successor to the 8-bit shift-add multiplier.
- Adds the following over the 8-bit block:
  - generic operand width
  - signed or unsigned operation, selected per operation
  - explicit start/busy/rdy handshake
  - one Booth digit (two multiplier bits) retired per clock
- Used by datapath blocks that need a small, low-area multiplier where multi-cycle latency is acceptable.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 4; elaboration fails otherwise.
- DIGITS, WIDTH/2+1, derived (localparam, not overridable): number of Booth digits = number of compute cycles.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a new multiplication; sampled only when the block accepts (IDLE or DONE).
- signed_mode  input  1  1 = a and b are two's complement; 0 = unsigned. Sampled with start.
- a  input  WIDTH  multiplicand, sampled with start.
- b  input  WIDTH  multiplier, sampled with start.
- busy  output  1  high while in CALC.
- rdy  output  1  one-cycle pulse: p holds a new valid result.
- p  output  2*WIDTH  product. Holds the last result until the next completion.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state = IDLE; p = 0, rdy = 0, busy = 0.
  - Internal accumulator, operand registers and counter cleared.
  - An in-flight operation is discarded; no rdy is produced for it.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at an edge: latch the operands, counter = DIGITS, go to CALC.
  - start=0: stay in IDLE.
- Operand latching:
  - Multiplicand M = a extended to WIDTH+2 bits.
  - Multiplier Q = {b extended to WIDTH+2 bits, 1'b0}.
  - Extension is the sign bit when signed_mode=1, zero when signed_mode=0.
  - The extra bits make unsigned operands representable as signed, so one datapath serves both modes.
- CALC, each cycle:
  - Decode the 3-bit window Q[2:0] into a digit d in {0, +1, +2, -1, -2}.
  - acc = acc + d*M, with the partial product aligned to the current digit position.
  - Shift Q right by 2 (arithmetic).
  - Decrement the counter.
  - Accumulator width: 2*WIDTH+4 bits, signed, no overflow possible.
  - -M and -2M are formed as two's complement of the extended M.
- CALC, last digit (counter reaches 1): at that edge load p = acc_final[2*WIDTH-1:0] and go to DONE. The result is exact for both modes.
- DONE (one cycle): rdy = 1, busy = 0.
  - start=1: accept back-to-back (same actions as IDLE) and go to CALC.
  - start=0: go to IDLE.
- Latency: start sampled at edge t0 -> busy=1 from t0 -> p valid and rdy=1 after edge t0+DIGITS -> rdy low after t0+DIGITS+1. For WIDTH=8: 5 compute cycles.
- Throughput: one result every DIGITS+1 cycles with start held high.
- start while busy (CALC): ignored. No queueing, and the in-flight operands are unaffected.
- Changes on a, b and signed_mode outside the accept edge have no effect.
- p changes only on a result load or on reset.
- rdy is never high in the same cycle as busy.

Decomposition:
- Shared package booth_pkg holds:
  - state enum {IDLE, CALC, DONE}
  - Booth digit encoding constants (ZERO, POS1, POS2, NEG1, NEG2)
  - function computing DIGITS from WIDTH
- One natural sub-module: booth_r4_digit.
  - Purely combinational.
  - Input: 3-bit window and the extended M.
  - Output: the signed partial product (WIDTH+3 bits).
  - Shared by future array and pipelined multiplier variants.

Test Plan:
- WIDTH=8, signed: a=8'h80, b=8'h80 (-128 x -128) -> after 5 CALC cycles p=16'h4000, rdy pulses exactly once, busy high for exactly 5 cycles.
- WIDTH=8, unsigned: a=8'hFF, b=8'hFF -> p=16'hFE01. Same a/b with signed=1 -> p=16'h0001.
- WIDTH=8, signed: a=8'h7F, b=8'h80 -> p=16'hC080. a=8'hFF, b=8'h01 -> p=16'hFFFF. a=0, b=8'h5A -> p=0.
- start pulsed again in the 2nd CALC cycle with new operands -> ignored, the first result is correct. start held high through DONE -> back-to-back results 6 cycles apart, each correct.
- Assert reset in the 3rd CALC cycle -> p=0, rdy=0, busy=0 immediately (asynchronous). No rdy follows. A subsequent start produces a correct result.
- WIDTH=16 and WIDTH=4 builds: random signed/unsigned operands vs. a reference model, 10k operations each. Check latency = WIDTH/2+1 and that p holds stable between rdy pulses.

Source files
------------

// File: rtl/booth_r4_mul_seq_pkg.sv
// Shared definitions for the radix-4 Booth multiplier family.
// Holds the controller state encoding, the Booth digit encoding, the
// window-to-digit decode and the digit-count helper used to size datapaths.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } digit_t;

  // One Booth digit per multiplier bit pair, plus one extra digit to absorb
  // the two extension bits that make unsigned operands look signed.
  function automatic int booth_digits(input int width);
    return width / 2 + 1;
  endfunction

  // Window is {q[2*i+1], q[2*i], q[2*i-1]}.
  function automatic digit_t booth_decode(input logic [2:0] win);
    digit_t d;
    case (win)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_mul_seq_digit.sv
// Radix-4 Booth partial-product generator for one digit.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
// Ports: win_i  - 3-bit multiplier window
//        m_i    - multiplicand, already extended to WIDTH+2 bits (signed)
//        pp_o   - signed partial product d*M, WIDTH+3 bits
module booth_r4_digit
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       win_i,
  input  logic [WIDTH+1:0] m_i,
  output logic [WIDTH+2:0] pp_o
);

  logic [WIDTH+2:0] m1;
  logic [WIDTH+2:0] m2;

  // One extra bit of headroom so that +/-2M never overflows.
  assign m1 = {m_i[WIDTH+1], m_i};
  assign m2 = {m_i, 1'b0};

  always_comb begin
    pp_o = '0;
    case (booth_decode(win_i))
      POS1:    pp_o = m1;
      POS2:    pp_o = m2;
      NEG1:    pp_o = -m1;
      NEG2:    pp_o = -m2;
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_mul_seq.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per operation.
// Latency: WIDTH/2+1 cycles from the accepting edge to the rdy pulse.
// Backpressure: start is ignored while busy; no queueing of requests.
// Ports: clk, reset (async, active-high); start/signed_mode/a/b sampled on
//        the accept edge (IDLE or DONE); busy high in CALC; rdy one-cycle
//        pulse in DONE; p holds the last product until the next completion.
module booth_r4_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               rdy,
  output logic [2*WIDTH-1:0] p
);
  import booth_pkg::*;

  localparam int DIGITS = booth_digits(WIDTH);
  localparam int MW     = WIDTH + 2;       // extended multiplicand
  localparam int QW     = WIDTH + 3;       // extended multiplier plus q[-1]
  localparam int AW     = 2 * WIDTH + 4;   // accumulator
  localparam int CW     = $clog2(DIGITS + 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
    $error("booth_r4_mul_seq: WIDTH must be even and >= 4");
  end

  state_t               state_q, state_d;
  logic [MW-1:0]        m_q, m_d;
  logic [QW-1:0]        q_q, q_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;

  logic [QW-1:0]        pp;
  logic [AW-1:0]        pp_ext;
  logic [AW-1:0]        acc_sum;
  logic [AW-1:0]        acc_shift;
  logic                 a_sx;
  logic                 b_sx;

  booth_r4_digit #(.WIDTH(WIDTH)) u_digit (
    .win_i (q_q[2:0]),
    .m_i   (m_q),
    .pp_o  (pp)
  );

  // Each partial product enters at the top (weight 2^MW) and the whole
  // accumulator shifts right two places per digit. After DIGITS steps every
  // digit has landed at its true weight 4^i; the bits shifted out are always
  // zero, so the product is exact without a variable shifter.
  assign pp_ext    = {{(AW-QW){pp[QW-1]}}, pp} << MW;
  assign acc_sum   = acc_q + pp_ext;
  assign acc_shift = $unsigned($signed(acc_sum) >>> 2);

  assign a_sx = signed_mode & a[WIDTH-1];
  assign b_sx = signed_mode & b[WIDTH-1];

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d     = {{2{a_sx}}, a};
          q_d     = {{2{b_sx}}, b, 1'b0};
          acc_d   = '0;
          cnt_d   = CW'(DIGITS);
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = acc_shift;
        q_d   = $unsigned($signed(q_q) >>> 2);
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          p_d     = acc_shift[2*WIDTH-1:0];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign busy = (state_q == CALC);
  assign rdy  = (state_q == DONE);
  assign p    = p_q;

endmodule
